// File: rtl/btn_updown_seg_mux.sv
// Debounced up/down/clear push-button counter, NDIG hex/BCD digits with carry and borrow,
// driving a time-multiplexed active-low seven-segment display.
module btn_updown_seg_mux #(
   parameter int NDIG        = 4,
   parameter int DEB_CYCLES  = 1000000,
   parameter int SCAN_CYCLES = 100000,
   parameter int LZB         = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_clr,
   input  logic              mode_dec,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [NDIG*4-1:0] led
);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NDIG - 1);

   logic [2:0]    raw, sync1, sync2, deb, deb_q, arm, pulse;
   logic [1:0]    sync_ok;
   logic [DW-1:0] deb_cnt [3];
   logic          mode_s1, mode_s2, mode_q, mode_chg;
   logic [3:0]    digits [NDIG];
   logic [3:0]    nxt [NDIG];
   logic [3:0]    dmax;
   logic          wrap, wrap_nxt, cy, allz;
   logic [NDIG-1:0] blank, an_n;
   logic [IW-1:0] idx;
   logic [SW-1:0] tmr;

   assign raw = {btn_clr, btn_down, btn_up};
   // arm blocks the pulse of a button that was already held when reset released
   assign pulse = deb & ~deb_q & arm;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         deb     <= '0;
         deb_q   <= '0;
         arm     <= '0;
         sync_ok <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         deb_q   <= deb;
         sync_ok <= {sync_ok[0], 1'b1};
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_MAX) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
            if (sync_ok[1] && !sync2[i]) arm[i] <= 1'b1;
         end
      end
   end

   assign mode_chg = mode_s2 != mode_q;
   assign dmax     = mode_s2 ? 4'd9 : 4'hF;

   always_comb begin
      nxt      = digits;
      wrap_nxt = wrap;
      cy       = 1'b1;
      if (pulse[2]) begin
         for (int i = 0; i < NDIG; i++) nxt[i] = 4'h0;
         wrap_nxt = 1'b0;
      end else if (mode_chg) begin
         for (int i = 0; i < NDIG; i++) nxt[i] = 4'h0;
      end else if (pulse[0] && !pulse[1]) begin
         for (int i = 0; i < NDIG; i++) begin
            if (cy) begin
               if (digits[i] == dmax) nxt[i] = 4'h0;
               else begin
                  nxt[i] = digits[i] + 4'd1;
                  cy     = 1'b0;
               end
            end
         end
         if (cy) wrap_nxt = 1'b1;
      end else if (pulse[1] && !pulse[0]) begin
         for (int i = 0; i < NDIG; i++) begin
            if (cy) begin
               if (digits[i] == 4'h0) nxt[i] = dmax;
               else begin
                  nxt[i] = digits[i] - 4'd1;
                  cy     = 1'b0;
               end
            end
         end
         if (cy) wrap_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
         mode_q  <= 1'b0;
         wrap    <= 1'b0;
         for (int i = 0; i < NDIG; i++) digits[i] <= 4'h0;
      end else begin
         mode_s1 <= mode_dec;
         mode_s2 <= mode_s1;
         mode_q  <= mode_s2;
         wrap    <= wrap_nxt;
         digits  <= nxt;
      end
   end

   always_comb begin
      led = '0;
      for (int i = 0; i < NDIG; i++) led[i*4 +: 4] = digits[i];
   end

   // digit i is blank when it and everything above it are zero; digit 0 never blanks
   always_comb begin
      blank = '0;
      allz  = 1'b1;
      for (int i = NDIG - 1; i > 0; i--) begin
         allz     = allz & (digits[i] == 4'h0);
         blank[i] = (LZB != 0) && allz;
      end
      for (int i = 0; i < NDIG; i++) an_n[i] = (idx != IW'(i));
   end

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         tmr <= '0;
         an  <= ~NDIG'(1);
         seg <= 7'b1000000;
         dp  <= 1'b1;
      end else begin
         if (tmr == SCAN_MAX) begin
            tmr <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            tmr <= tmr + 1'b1;
         end
         an  <= an_n;
         seg <= blank[idx] ? 7'b1111111 : glyph(digits[idx]);
         dp  <= ~((idx == '0) & wrap);
      end
   end
endmodule

// File: tb/tb_btn_updown_seg_mux.sv
// Directed bench for btn_updown_seg_mux: vector table of button/mode actions plus
// hand sequences for latency, bounce, wrap/dp, scanning and reset-during-press.
module tb_btn_updown_seg_mux;
   localparam int OP_UP = 0, OP_DOWN = 1, OP_CLR = 2, OP_BOTH = 3, OP_MODE0 = 4, OP_MODE1 = 5;
   localparam int NVEC = 19;

   typedef struct {
      int          op;
      int          n;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0, mode_dec = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] led;
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs [NVEC];

   always #5 clk = ~clk;

   btn_updown_seg_mux #(.NDIG(4), .DEB_CYCLES(4), .SCAN_CYCLES(8), .LZB(1)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
      .mode_dec(mode_dec), .an(an), .seg(seg), .dp(dp), .led(led)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0; mode_dec = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(5);
   endtask

   task automatic press(input int which, input int n);
      for (int k = 0; k < n; k++) begin
         btn_up   = (which == OP_UP)   || (which == OP_BOTH);
         btn_down = (which == OP_DOWN) || (which == OP_BOTH);
         btn_clr  = (which == OP_CLR);
         tick(10);
         btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
         tick(10);
      end
   endtask

   task automatic wait_an(input logic [3:0] target, input string name);
      int c;
      c = 0;
      while (an !== target && c < 40) begin
         tick(1);
         c++;
      end
      if (an !== target) begin
         checks++;
         errors++;
         $display("FAIL %s: digit enable %b never seen, an=%b", name, target, an);
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev, an_start, exp_an;
      logic [3:0] an_seen [4];
      logic [6:0] seg_seen [4];
      int         t_seen [4];
      int         nchg;

      vecs[0]  = '{OP_UP,    1,   16'h0001};
      vecs[1]  = '{OP_UP,    4,   16'h0005};
      vecs[2]  = '{OP_DOWN,  5,   16'h0000};
      vecs[3]  = '{OP_DOWN,  1,   16'hFFFF};
      vecs[4]  = '{OP_UP,    1,   16'h0000};
      vecs[5]  = '{OP_CLR,   1,   16'h0000};
      vecs[6]  = '{OP_BOTH,  1,   16'h0000};
      vecs[7]  = '{OP_MODE1, 1,   16'h0000};
      vecs[8]  = '{OP_UP,    99,  16'h0099};
      vecs[9]  = '{OP_UP,    1,   16'h0100};
      vecs[10] = '{OP_DOWN,  1,   16'h0099};
      vecs[11] = '{OP_BOTH,  1,   16'h0099};
      vecs[12] = '{OP_MODE0, 1,   16'h0000};
      vecs[13] = '{OP_UP,    255, 16'h00FF};
      vecs[14] = '{OP_UP,    1,   16'h0100};
      vecs[15] = '{OP_MODE1, 1,   16'h0000};
      vecs[16] = '{OP_DOWN,  1,   16'h9999};
      vecs[17] = '{OP_UP,    1,   16'h0000};
      vecs[18] = '{OP_MODE0, 1,   16'h0000};

      // reset state
      do_reset();
      check("reset_an", 32'(an), 32'h0000000E);
      check("reset_seg", 32'(seg), 32'h00000040);
      check("reset_dp", 32'(dp), 32'h1);
      check("reset_led", 32'(led), 32'h0);

      // press latency: led changes on posedge 7 after the raw rise
      btn_up = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         if (k == 6) check("latency_pe6", 32'(led), 32'h0);
         if (k == 7) check("latency_pe7", 32'(led), 32'h1);
      end
      tick(13);
      check("held_no_repeat", 32'(led), 32'h1);
      btn_up = 1'b0;
      tick(10);
      check("release_no_action", 32'(led), 32'h1);

      // bounce shorter than the debounce window is rejected
      do_reset();
      for (int k = 0; k < 15; k++) begin
         btn_up = ~btn_up;
         tick(2);
      end
      btn_up = 1'b0;
      tick(10);
      check("bounce_rejected", 32'(led), 32'h0);

      // vector table
      do_reset();
      for (int v = 0; v < NVEC; v++) begin
         case (vecs[v].op)
            OP_MODE0: begin mode_dec = 1'b0; tick(10); end
            OP_MODE1: begin mode_dec = 1'b1; tick(10); end
            default:  press(vecs[v].op, vecs[v].n);
         endcase
         check($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp));
      end

      // borrow out of the top digit sets wrap; dp shows it on digit 0 only
      do_reset();
      press(OP_DOWN, 1);
      check("wrap_led", 32'(led), 32'h0000FFFF);
      wait_an(4'b1110, "wrap_digit0");
      check("wrap_dp_digit0", 32'(dp), 32'h0);
      check("wrap_seg_F", 32'(seg), 32'h0E);
      wait_an(4'b1101, "wrap_digit1");
      check("wrap_dp_digit1", 32'(dp), 32'h1);
      mode_dec = 1'b1;
      tick(10);
      check("mode_clear_led", 32'(led), 32'h0);
      wait_an(4'b1110, "mode_digit0");
      check("mode_keeps_wrap", 32'(dp), 32'h0);
      check("mode_seg_0", 32'(seg), 32'h40);
      mode_dec = 1'b0;
      tick(10);
      press(OP_CLR, 1);
      check("clr_led", 32'(led), 32'h0);
      wait_an(4'b1110, "clr_digit0");
      check("clr_dp", 32'(dp), 32'h1);

      // scanning with leading-zero blanking
      do_reset();
      press(OP_UP, 5);
      check("scan_led", 32'(led), 32'h5);
      an_start = an;
      prev = an;
      nchg = 0;
      for (int c = 0; c < 48; c++) begin
         tick(1);
         if (an !== prev && nchg < 4) begin
            an_seen[nchg]  = an;
            seg_seen[nchg] = seg;
            t_seen[nchg]   = c;
            nchg++;
         end
         prev = an;
      end
      check("scan_changes", 32'(nchg), 32'd4);
      for (int k = 0; k < nchg; k++) begin
         prev   = (k == 0) ? an_start : an_seen[k-1];
         exp_an = {prev[2:0], prev[3]};
         check($sformatf("scan_an%0d", k), 32'(an_seen[k]), 32'(exp_an));
         check($sformatf("scan_seg%0d", k), 32'(seg_seen[k]),
               (exp_an == 4'b1110) ? 32'h12 : 32'h7F);
         if (k > 0) check($sformatf("scan_period%0d", k), 32'(t_seen[k] - t_seen[k-1]), 32'd8);
      end

      // reset in the middle of a press: no action until released and pressed again
      do_reset();
      btn_up = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(20);
      check("rst_mid_press_held", 32'(led), 32'h0);
      btn_up = 1'b0;
      tick(10);
      check("rst_mid_press_release", 32'(led), 32'h0);
      press(OP_UP, 1);
      check("rst_mid_press_repress", 32'(led), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
